am_inference_ctrl: RTL
======================

AM_INFERENCE_CTRL -- requirements
Module: am_inference_ctrl

Interface
REQ-001 SHALL have parameter NUM_SEG, default 20, number of hypervector segments fetched per query (legal range 1..255).
REQ-002 SHALL have parameter MEM_LAT, default 1, class-memory read latency in cycles (legal range 1..4).
REQ-003 SHALL have clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have nrst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have start_valid  input  1  query present and ready for inference.
REQ-006 SHALL have start_ready  output  1  controller can accept a query.
REQ-007 SHALL have abort  input  1  synchronous cancel of the current query.
REQ-008 SHALL have seg_rd_en  output  1  class/query memory read strobe.
REQ-009 SHALL have seg_addr  output  8  segment index being read.
REQ-010 SHALL have acc_clr  output  1  clears the 26 similarity accumulators.
REQ-011 SHALL have acc_en  output  1  accumulators add the segment data returned by memory this cycle.
REQ-012 SHALL have inferring_class  output  1  enables the tree comparator.
REQ-013 SHALL have class_inference  input  5  comparator winning class (0..25).
REQ-014 SHALL have result_valid  output  1  result_class holds a completed inference.
REQ-015 SHALL have result_ready  input  1  consumer accepts the result.
REQ-016 SHALL have result_class  output  5  registered winning class.
REQ-017 SHALL have busy  output  1  high in every state except IDLE.
REQ-018 SHALL have infer_count  output  16  number of results consumed; wraps at 65535 -> 0.

Function
REQ-019 SHALL implement states IDLE, CLEAR, FETCH, DRAIN, COMPARE, HOLD.
REQ-020 start_ready SHALL be 1 only in IDLE; a query is accepted when start_valid && start_ready, and the next state is CLEAR.
REQ-021 CLEAR SHALL last 1 cycle with acc_clr=1, then go to FETCH with the segment counter at 0.
REQ-022 FETCH SHALL assert seg_rd_en each cycle with seg_addr = 0,1,...,NUM_SEG-1 on consecutive cycles, then go to DRAIN; seg_addr SHALL be 0 outside FETCH.
REQ-023 acc_en SHALL equal seg_rd_en delayed by exactly MEM_LAT cycles through an internal shift register, so there are exactly NUM_SEG acc_en pulses per query.
REQ-024 DRAIN SHALL last exactly MEM_LAT cycles, covering the final acc_en, then go to COMPARE.
REQ-025 COMPARE SHALL last 1 cycle with inferring_class=1; class_inference SHALL be registered into result_class at the end of that cycle; next state is HOLD.
REQ-026 inferring_class SHALL be 0 in every state other than COMPARE.
REQ-027 HOLD SHALL drive result_valid=1 with result_class stable until result_valid && result_ready; then infer_count increments by 1 and the next state is IDLE.
REQ-028 A new query SHALL NOT be accepted in the cycle a result is consumed; start_ready rises the following cycle.
REQ-029 Latency: if the query is accepted in cycle 0, result_valid SHALL first be high in cycle NUM_SEG+MEM_LAT+3 (cycle 24 at defaults).
REQ-030 abort=1 in any non-IDLE state SHALL force IDLE next cycle, flush the acc_en shift register to 0, and leave result_class and infer_count unchanged.
REQ-031 In HOLD, abort and result_ready high in the same cycle: abort SHALL win, the result is discarded, and infer_count is not incremented.
REQ-032 abort in IDLE SHALL have no effect; if start_valid is also high, abort SHALL win and the query is not accepted.
REQ-033 result_class SHALL hold its last value outside HOLD and is only valid while result_valid=1.

Reset
REQ-034 nrst=1 SHALL, at the next clock edge, set state IDLE, all counters and the shift register to 0, and seg_rd_en, acc_en, acc_clr, inferring_class, result_valid, busy, seg_addr, result_class and infer_count to 0; start_ready is 1 after reset.
REQ-035 nrst SHALL take priority over abort and all handshakes, including mid-FETCH and in HOLD.

Verification
REQ-036 Defaults; start_valid in cycle 0; class_inference=17; result_ready=1 -> acc_clr in cycle 1; seg_addr 0..19 in cycles 2..21; acc_en in cycles 3..22; inferring_class in cycle 23; result_valid and result_class=17 in cycle 24; infer_count=1.
REQ-037 result_ready held low for 10 cycles in HOLD -> result_valid stays 1 and result_class stays stable; infer_count increments only on the accepting cycle; start_ready is 1 the cycle after acceptance.
REQ-038 abort at seg_addr=7 -> IDLE next cycle; no further acc_en pulses; no result_valid; infer_count unchanged.
REQ-039 MEM_LAT=3, NUM_SEG=4 -> exactly 4 acc_en pulses in cycles 5..8; inferring_class in cycle 9; result_valid in cycle 10.
REQ-040 nrst asserted mid-DRAIN -> all outputs at reset values next cycle; the following query completes normally.
REQ-041 256 consecutive queries, plus a preset count at 65535 -> infer_count wraps to 0.

Source files
------------

// File: rtl/am_inference_ctrl.sv
// Sequencer for an associative-memory inference pass: clears the similarity
// accumulators, streams NUM_SEG segments from class memory, then latches the winner.
module am_inference_ctrl #(
  parameter int unsigned NUM_SEG = 20,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       start_valid,
  output logic       start_ready,
  input  logic       abort,
  output logic       seg_rd_en,
  output logic [7:0] seg_addr,
  output logic       acc_clr,
  output logic       acc_en,
  output logic       inferring_class,
  input  logic [4:0] class_inference,
  output logic       result_valid,
  input  logic       result_ready,
  output logic [4:0] result_class,
  output logic       busy,
  output logic [15:0] infer_count
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    FETCH   = 3'd2,
    DRAIN   = 3'd3,
    COMPARE = 3'd4,
    HOLD    = 3'd5
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic [7:0]         cnt;
  logic [MEM_LAT-1:0] lat_sr;
  logic [4:0]         class_q;
  logic [15:0]        count_q;
  logic               last_seg;
  logic               last_drain;
  logic               kill;
  logic               consume;

  assign last_seg   = (cnt == 8'(NUM_SEG - 1));
  assign last_drain = (cnt == 8'(MEM_LAT - 1));
  assign kill       = abort && (state != IDLE);
  assign consume    = (state == HOLD) && result_ready && !abort;

  always_ff @(posedge clk) begin
    if (nrst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx        = state;
    start_ready     = 1'b0;
    seg_rd_en       = 1'b0;
    seg_addr        = '0;
    acc_clr         = 1'b0;
    inferring_class = 1'b0;
    result_valid    = 1'b0;
    busy            = 1'b1;
    case (state)
      IDLE: begin
        start_ready = 1'b1;
        busy        = 1'b0;
        // abort outranks a simultaneous start request
        if (start_valid && !abort) begin
          state_nx = CLEAR;
        end
      end
      CLEAR: begin
        acc_clr  = 1'b1;
        state_nx = FETCH;
      end
      FETCH: begin
        seg_rd_en = 1'b1;
        seg_addr  = cnt;
        if (last_seg) begin
          state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (last_drain) begin
          state_nx = COMPARE;
        end
      end
      COMPARE: begin
        inferring_class = 1'b1;
        state_nx        = HOLD;
      end
      HOLD: begin
        result_valid = 1'b1;
        if (result_ready) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
    if (kill) begin
      state_nx = IDLE;
    end
  end

  // One counter serves both the segment index and the drain timer; it
  // restarts on every state change.
  always_ff @(posedge clk) begin
    if (nrst) begin
      cnt <= '0;
    end else if (state_nx != state) begin
      cnt <= '0;
    end else if (state == FETCH || state == DRAIN) begin
      cnt <= cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (nrst || kill) begin
      lat_sr <= '0;
    end else begin
      lat_sr <= MEM_LAT'({lat_sr, seg_rd_en});
    end
  end

  assign acc_en = lat_sr[MEM_LAT-1];

  always_ff @(posedge clk) begin
    if (nrst) begin
      class_q <= '0;
    end else if (state == COMPARE && !abort) begin
      class_q <= class_inference;
    end
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      count_q <= '0;
    end else if (consume) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign result_class = class_q;
  assign infer_count  = count_q;

endmodule
